// File: rtl/kb_pkg.sv
`default_nettype none
// kb_pkg -- shared types and constants for the keyboard-to-UART keycode path.
// Rev 1.0
package kb_pkg;

  localparam int KEY_W           = 8;
  localparam int CLK_HZ          = 12_000_000;
  localparam int BAUD            = 9600;
  localparam int UART_FRAME_BITS = 10;

  // One UART byte is start + 8 data + stop bits at BAUD.
  function automatic int frame_cycles(input int clk_hz, input int baud);
    return (clk_hz / baud) * UART_FRAME_BITS;
  endfunction

  localparam int DEFAULT_FRAME_CYCLES = frame_cycles(CLK_HZ, BAUD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/keycode_buffer_sync_fifo.sv
`default_nettype none
// sync_fifo -- single-clock FIFO with occupancy count; push into a full FIFO is accepted only alongside a pop.
// Rev 1.0
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (o_count == FULL_COUNT);
  assign o_empty = (o_count == '0);
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);
  assign o_data  = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/keycode_buffer.sv
`default_nettype none
// keycode_buffer -- queues keycodes from kb_interface and paces them out to UART_transmit, one per frame.
// Rev 1.0
module keycode_buffer
  import kb_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int FRAME_CYCLES = DEFAULT_FRAME_CYCLES
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [KEY_W:0]         i_keycode,
  input  logic                   i_ready,
  output logic [KEY_W-1:0]       o_to_send,
  output logic                   o_send,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  drain_state_t     state;
  drain_state_t     state_next;
  logic [CNT_W-1:0] frame_cnt;
  logic             ready_d;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [KEY_W-1:0] head;
  logic             unused_keycode_lsb;

  assign unused_keycode_lsb = i_keycode[0];
  assign push = i_ready & ~ready_d;
  assign pop  = (state == IDLE) & ~empty;

  sync_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (i_keycode[KEY_W:1]),
    .o_data  (head),
    .o_count (o_count),
    .o_full  (full),
    .o_empty (empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_d    <= 1'b0;
      o_overflow <= 1'b0;
      o_to_send  <= '0;
      frame_cnt  <= '0;
    end else begin
      ready_d <= i_ready;
      if (push && full && !pop) o_overflow <= 1'b1;
      if (pop) o_to_send <= head;
      if (state == SEND)
        frame_cnt <= CNT_W'(FRAME_CYCLES - 1);
      else if (state == WAIT && frame_cnt != '0)
        frame_cnt <= frame_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Leaving WAIT on the step down to zero keeps send-to-send spacing at FRAME_CYCLES+1.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = SEND;
      SEND:    state_next = WAIT;
      WAIT:    if (frame_cnt <= CNT_W'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_send = (state == SEND);
  end

endmodule
`default_nettype wire

// File: tb/tb_keycode_buffer.sv
`default_nettype none
// tb_keycode_buffer -- directed self-checking bench for keycode_buffer (DEPTH=4, FRAME_CYCLES=20).
// Rev 1.0
module tb_keycode_buffer;

  localparam int DEPTH = 4;
  localparam int FRAME = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [8:0] keycode = '0;
  logic       ready = 1'b0;
  logic [7:0] to_send;
  logic       send;
  logic [2:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise;
  int s0;
  logic [7:0] sent_q[$];
  int         send_cyc[$];
  logic [7:0] v6 [10] = '{8'h01, 8'h80, 8'hFF, 8'h5A, 8'hA5, 8'h7E, 8'hC3, 8'h24, 8'h99, 8'h66};

  keycode_buffer #(
    .DEPTH        (DEPTH),
    .FRAME_CYCLES (FRAME)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_keycode  (keycode),
    .i_ready    (ready),
    .o_to_send  (to_send),
    .o_send     (send),
    .o_count    (count),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (send) begin
      sent_q.push_back(to_send);
      send_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sent_at(input int i);
    return (i < sent_q.size()) ? {24'h0, sent_q[i]} : 32'hDEAD;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < send_cyc.size()) ? send_cyc[i] : -1000;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(posedge clk); #1;
    keycode = {b, 1'b1};
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic do_reset;
    ready = 1'b0;
    rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic clear_log;
    sent_q.delete();
    send_cyc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_to_send", to_send, 0);
    check("rst_send", send, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    tick(3);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // 1: long ready level produces one byte
    clear_log();
    @(posedge clk); #1;
    keycode = 9'h1C2;
    ready = 1'b1;
    rise = cyc;
    tick(10);
    ready = 1'b0;
    tick(30);
    check("t1_num_sent", sent_q.size(), 1);
    check("t1_byte", sent_at(0), 32'hE1);
    check("t1_send_cycle", cyc_at(0), rise + 2);
    check("t1_count", count, 0);

    // 2: burst of three, ordered and paced
    clear_log();
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    tick(10);
    check("t2_hold", to_send, 32'h11);
    check("t2_count_mid", count, 2);
    tick(70);
    check("t2_num_sent", sent_q.size(), 3);
    check("t2_byte0", sent_at(0), 32'h11);
    check("t2_byte1", sent_at(1), 32'h22);
    check("t2_byte2", sent_at(2), 32'h33);
    check("t2_gap01", cyc_at(1) - cyc_at(0), FRAME + 1);
    check("t2_gap12", cyc_at(2) - cyc_at(1), FRAME + 1);
    check("t2_hold_last", to_send, 32'h33);

    // 3: six pushes inside one frame overflow a 4-deep FIFO
    clear_log();
    push_byte(8'hA0);
    tick(3);
    check("t3_ovf_before", overflow, 0);
    for (int i = 1; i <= 6; i++) push_byte(8'hA0 + 8'(i));
    check("t3_count_full", count, 4);
    check("t3_ovf_set", overflow, 1);
    tick(5 * (FRAME + 1) + 10);
    check("t3_num_sent", sent_q.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("t3_byte%0d", i), sent_at(i), 32'hA0 + i);
    check("t3_ovf_sticky", overflow, 1);
    check("t3_count_drained", count, 0);

    // 4: push on the same edge as a pop while full
    do_reset();
    check("t4_ovf_cleared", overflow, 0);
    clear_log();
    push_byte(8'hB0);
    tick(2);
    s0 = cyc_at(0);
    for (int i = 1; i <= 4; i++) push_byte(8'hB0 + 8'(i));
    check("t4_count_full", count, 4);
    wait_cycle(s0 + FRAME);
    keycode = {8'hB5, 1'b0};
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk);
    check("t4_send_now", send, 1);
    check("t4_popped", to_send, 32'hB1);
    check("t4_count_same", count, 4);
    check("t4_no_ovf", overflow, 0);
    tick(5 * (FRAME + 1) + 10);
    check("t4_num_sent", sent_q.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("t4_byte%0d", i), sent_at(i), 32'hB0 + i);
    check("t4_ovf_end", overflow, 0);

    // 5: asynchronous reset mid-WAIT
    clear_log();
    push_byte(8'hC0);
    push_byte(8'hC1);
    push_byte(8'hC2);
    tick(5);
    check("t5_count_pre", count, 2);
    check("t5_to_send_pre", to_send, 32'hC0);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_to_send", to_send, 0);
    check("t5_rst_send", send, 0);
    check("t5_rst_count", count, 0);
    check("t5_rst_overflow", overflow, 0);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    tick(60);
    check("t5_no_send_after", sent_q.size(), 0);

    // 6: ten single transfers wrap the pointers
    clear_log();
    for (int i = 0; i < 10; i++) begin
      push_byte(v6[i]);
      tick(22);
    end
    tick(30);
    check("t6_num_sent", sent_q.size(), 10);
    for (int i = 0; i < 10; i++) check($sformatf("t6_byte%0d", i), sent_at(i), {24'h0, v6[i]});
    check("t6_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
